// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// FSM state encoding, register constants and M-bundle layout.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         M_MEMREAD = 1;

  // A source depends on a load destination unless that destination is $zero.
  function automatic logic reg_dep(
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between IF/ID sources and the ID/EX load target.
// Purely combinational.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       valid,
  input  logic       memread,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  assign load_use = valid & memread &
                    (reg_dep(ex_rt, rs) | reg_dep(ex_rt, rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller.
// Load-use bubbles, memory freezes, timeout error, event counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_valid,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_br_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_nxt;
  logic              load_use;
  logic              do_freeze;
  logic              do_flush;
  logic              do_stall;
  logic              timeout;
  logic              hold;

  hazard_detect u_detect (
    .valid    (if_id_valid),
    .memread  (id_ex_memread),
    .rs       (if_id_rs),
    .rt       (if_id_rt),
    .ex_rt    (id_ex_rt),
    .load_use (load_use)
  );

  // Resolve this cycle's hazard by priority and pick the next state.
  always_comb begin
    do_freeze = 1'b0;
    do_flush  = 1'b0;
    do_stall  = 1'b0;
    timeout   = 1'b0;
    wait_nxt  = '0;
    state_nxt = ST_RUN;
    unique case (state)
      ST_ERROR: state_nxt = ST_ERROR;
      default: begin
        if (dmem_busy) begin
          do_freeze = 1'b1;
          wait_nxt  = (state == ST_FREEZE) ?
                      wait_q + 1'b1 : WAIT_W'(1);
          timeout   = (wait_nxt >= WAIT_MAX);
          state_nxt = timeout ? ST_ERROR : ST_FREEZE;
        end else if (ex_mem_br_taken) begin
          do_flush = 1'b1;
        end else if (load_use && state != ST_STALL) begin
          do_stall  = 1'b1;
          state_nxt = ST_STALL;
        end
      end
    endcase
  end

  assign hold = rst & (do_freeze | (state == ST_ERROR));

  // Zero-latency enable/flush decode; reset forces the idle pattern.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_freeze  = 1'b0;
    if (hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (rst && do_flush) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (rst && do_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // State, busy-wait count, sticky error and wrapping event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      wait_q    <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wait_q <= wait_nxt;
      if (timeout)  mem_err   <= 1'b1;
      if (do_stall) stall_cnt <= stall_cnt + 1'b1;
      if (do_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Watches the IF/ID register fields, the ID/EX control bundle, the EX/MEM branch outcome and the data-memory busy flag. Drives the PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls. Keeps a small FSM for load-use bubbles, memory freezes and a memory-timeout error, plus wrap-around stall/flush event counters.

## Interface
- CNT_W, 16, width of the event counters
- TIMEOUT, 64, max consecutive dmem_busy cycles before error (≥1)

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_id_rs  in  5  instr[25:21] held in IF/ID
- if_id_rt  in  5  instr[20:16] held in IF/ID
- if_id_valid  in  1  IF/ID holds a real instruction
- id_ex_memread  in  1  memRead bit of the ID/EX M bundle
- id_ex_rt  in  5  id_ex_instr20_16
- ex_mem_br_taken  in  1  resolved taken branch in EX/MEM
- dmem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  zero IF/ID
- id_ex_flush  out  1  load bubble (WB/M/EX = 0) into ID/EX
- ex_mem_flush  out  1  zero EX/MEM control
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_err  out  1  sticky timeout error
- state_o  out  2  current FSM state
- stall_cnt  out  CNT_W  load-use bubbles inserted
- flush_cnt  out  CNT_W  branch flushes performed

## Operation
- States: RUN=0, STALL=1, FREEZE=2, ERROR=3.
- load_use = if_id_valid & id_ex_memread & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
- Per-cycle priority: ERROR > dmem_busy > ex_mem_br_taken > load_use.
- RUN:
  - dmem_busy: pc_write = if_id_write = 0; pipe_freeze = 1. Go to FREEZE with wait counter = 1.
  - Else ex_mem_br_taken: if_id_flush = id_ex_flush = ex_mem_flush = 1; flush_cnt += 1; stay in RUN. A coincident load_use is discarded.
  - Else load_use: pc_write = if_id_write = 0; id_ex_flush = 1; stall_cnt += 1. Go to STALL.
  - Else all enables = 1, all flushes = 0.
- STALL: one cycle only. Load-use is not re-evaluated. Outputs as in RUN with no hazard. Return to RUN.
  - If dmem_busy: freeze instead and go to FREEZE.
  - If ex_mem_br_taken: flush as in RUN.
- FREEZE: same freeze outputs as RUN+dmem_busy; wait counter increments each busy cycle.
  - dmem_busy drops: go to RUN. That cycle is evaluated with RUN rules, so a pending branch or load_use acts immediately.
  - Wait counter reaches TIMEOUT while still busy: go to ERROR and set mem_err.
- ERROR: pc_write = if_id_write = 0, pipe_freeze = 1, all flushes = 0. Exits only on reset.
- Counters wrap modulo 2^CNT_W. Wait counter is $clog2(TIMEOUT+1) bits.

## Timing
- Reset (rst = 0, async): state = RUN, mem_err = 0, stall_cnt = flush_cnt = 0, wait counter = 0.
- Enable/flush outputs are combinational from state and inputs in the same cycle: zero-latency hazard response. During reset they take RUN/no-hazard values: pc_write = if_id_write = 1, all flushes and pipe_freeze = 0.
- State, counters and mem_err update on the rising clk edge. Counter increments are visible the cycle after the event.
- Load-use costs exactly one bubble cycle. Branch flush costs zero controller cycles.
- Reset asserted mid-FREEZE or in ERROR returns to RUN asynchronously and drops pipe_freeze immediately.

## Structure
- Shared package mips_pkg: state encoding constants (ST_RUN..ST_ERROR), REG_ZERO = 5'd0, M-bundle bit index of memRead.
- One sub-module: hazard_detect, the purely combinational load_use comparator. FSM, output decode and counters live in hazard_ctrl.

## Test plan
- Reset, then idle with no hazards: pc_write = if_id_write = 1, all flushes = 0, state_o = 0, counters = 0.
- id_ex_memread = 1, id_ex_rt = 8, if_id_rs = 8: one cycle of pc_write = 0, id_ex_flush = 1. Next cycle state_o = 1 and stall_cnt = 1. Following cycle pc_write = 1 with no second bubble.
- Same load-use with id_ex_rt = 0: no stall, stall_cnt stays 0.
- ex_mem_br_taken = 1 together with a load-use match: all three flushes = 1, no stall, flush_cnt = 1, stall_cnt = 0.
- dmem_busy high for 3 cycles with TIMEOUT = 64: pipe_freeze = 1 for exactly 3 cycles, then RUN resumes. Hold dmem_busy for 64 cycles: state_o = 3 and mem_err = 1. Asserting rst = 0 clears both.
- CNT_W = 4: insert 17 load-use stalls, stall_cnt reads 1 (wrap).
